// File: rtl/clk_div_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_gen_pkg
// Description : Shared constants and state encoding for the programmable
//               multi-channel clock divider.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_gen_pkg;

    // Smallest legal period: one high cycle plus one low cycle.
    localparam int unsigned c_MIN_RATIO = 2;

    // Shadow register contents out of reset.
    localparam int unsigned c_DEF_RATIO = 2;
    localparam int unsigned c_DEF_HIGH  = 1;

    // Per-channel state encoding.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } chan_state_t;

endpackage
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_chan
// Description : One divider channel. Holds the period counter, the shadow
//               ratio/high registers, operand clamping and the IDLE/RUN FSM.
//               Operands are only sampled at the start of a period, so the
//               output waveform is never truncated or stretched mid-period.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_chan
    import clk_div_gen_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic         i_sync,
    input  logic [W-1:0] i_ratio,
    input  logic [W-1:0] i_high,
    output logic         o_clk_out,
    output logic         o_tick_rise,
    output logic         o_tick_fall,
    output logic         o_running
);

    chan_state_t  r_state;
    logic [W-1:0] r_cnt;
    logic [W-1:0] r_ratio;
    logic [W-1:0] r_high;
    logic         r_clk_out;
    logic         r_tick_rise;
    logic         r_tick_fall;

    logic [W-1:0] w_ratio;
    logic [W-1:0] w_ratio_m1;
    logic [W-1:0] w_high;
    logic [W-1:0] w_cnt_nxt;
    logic         w_period_end;
    logic         w_start;

    // Clamp the incoming operands so every period has at least one high and one low cycle.
    always_comb begin
        w_ratio    = (i_ratio < W'(c_MIN_RATIO)) ? W'(c_MIN_RATIO) : i_ratio;
        w_ratio_m1 = w_ratio - W'(1);
        w_high     = i_high;
        if (i_high == '0) begin
            w_high = W'(1);
        end else if (i_high > w_ratio_m1) begin
            w_high = w_ratio_m1;
        end
    end

    // Period bookkeeping; a new period starts on sync, from idle, or at the end of a period,
    // but only while the channel is enabled.
    always_comb begin
        w_cnt_nxt    = r_cnt + W'(1);
        w_period_end = (r_state == ST_RUN) && (r_cnt == (r_ratio - W'(1)));
        w_start      = i_en && (i_sync || (r_state == ST_IDLE) || w_period_end);
    end

    // Channel FSM, counter, shadow registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ratio     <= W'(c_DEF_RATIO);
            r_high      <= W'(c_DEF_HIGH);
            r_clk_out   <= 1'b0;
            r_tick_rise <= 1'b0;
            r_tick_fall <= 1'b0;
        end else begin
            r_tick_rise <= 1'b0;
            r_tick_fall <= 1'b0;
            if (w_start) begin
                r_state     <= ST_RUN;
                r_ratio     <= w_ratio;
                r_high      <= w_high;
                r_cnt       <= '0;
                r_clk_out   <= 1'b1;
                r_tick_rise <= 1'b1;
            end else if (r_state == ST_RUN) begin
                if (w_period_end) begin
                    // Disabled at period end: park low.
                    r_state   <= ST_IDLE;
                    r_cnt     <= '0;
                    r_clk_out <= 1'b0;
                end else begin
                    r_cnt <= w_cnt_nxt;
                    if (w_cnt_nxt == r_high) begin
                        r_clk_out   <= 1'b0;
                        r_tick_fall <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_clk_out   = r_clk_out;
    assign o_tick_rise = r_tick_rise;
    assign o_tick_fall = r_tick_fall;
    assign o_running   = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: rtl/clk_div_gen.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_gen
// Description : Multi-channel programmable clock generator. Instantiates CH
//               independent divider channels that share only the clock,
//               reset and the global phase-realign strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_gen
    import clk_div_gen_pkg::*;
#(
    parameter int CH = 4,
    parameter int W  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH-1:0]   en,
    input  logic            sync,
    input  logic [CH*W-1:0] div_ratio,
    input  logic [CH*W-1:0] high_cnt,
    output logic [CH-1:0]   clk_out,
    output logic [CH-1:0]   tick_rise,
    output logic [CH-1:0]   tick_fall,
    output logic [CH-1:0]   running
);

    // One divider per channel, each taking its own slice of the packed operand buses.
    for (genvar g = 0; g < CH; g++) begin : g_chan
        clk_div_chan #(
            .W (W)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_en        (en[g]),
            .i_sync      (sync),
            .i_ratio     (div_ratio[g*W +: W]),
            .i_high      (high_cnt[g*W +: W]),
            .o_clk_out   (clk_out[g]),
            .o_tick_rise (tick_rise[g]),
            .o_tick_fall (tick_fall[g]),
            .o_running   (running[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_gen
// Description : Self-checking bench for clk_div_gen. A vector table covers
//               basic division and operand clamping; directed sequences cover
//               ratio change, graceful stop, re-enable, sync and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_gen;

    localparam int CH = 4;
    localparam int W  = 8;

    logic            clk;
    logic            rst_n;
    logic [CH-1:0]   en;
    logic            sync;
    logic [CH*W-1:0] div_ratio;
    logic [CH*W-1:0] high_cnt;
    logic [CH-1:0]   clk_out;
    logic [CH-1:0]   tick_rise;
    logic [CH-1:0]   tick_fall;
    logic [CH-1:0]   running;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic            rst_n;
        logic [CH-1:0]   en;
        logic            sync;
        logic [CH*W-1:0] ratio;
        logic [CH*W-1:0] high;
        logic [CH-1:0]   e_clk;
        logic [CH-1:0]   e_rise;
        logic [CH-1:0]   e_fall;
        logic [CH-1:0]   e_run;
    } vec_t;

    vec_t tbl[$];

    clk_div_gen #(
        .CH (CH),
        .W  (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sync      (sync),
        .div_ratio (div_ratio),
        .high_cnt  (high_cnt),
        .clk_out   (clk_out),
        .tick_rise (tick_rise),
        .tick_fall (tick_fall),
        .running   (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CH*W-1:0] pk(input logic [W-1:0] a0, input logic [W-1:0] a1,
                                           input logic [W-1:0] a2, input logic [W-1:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic chk(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got %b want %b", name, act, exp);
    endtask

    // Apply inputs, clock one edge, then compare the registered outputs.
    task automatic step(input string name, input logic r, input logic [CH-1:0] e, input logic s,
                        input logic [CH*W-1:0] rat, input logic [CH*W-1:0] hi,
                        input logic [CH-1:0] xc, input logic [CH-1:0] xr,
                        input logic [CH-1:0] xf, input logic [CH-1:0] xu);
        rst_n = r; en = e; sync = s; div_ratio = rat; high_cnt = hi;
        @(posedge clk);
        #1;
        chk({name, " clk_out"},   clk_out,   xc);
        chk({name, " tick_rise"}, tick_rise, xr);
        chk({name, " tick_fall"}, tick_fall, xf);
        chk({name, " running"},   running,   xu);
    endtask

    task automatic add(input logic r, input logic [CH-1:0] e, input logic s,
                       input logic [CH*W-1:0] rat, input logic [CH*W-1:0] hi,
                       input logic [CH-1:0] xc, input logic [CH-1:0] xr,
                       input logic [CH-1:0] xf, input logic [CH-1:0] xu);
        vec_t v;
        v.rst_n = r; v.en = e; v.sync = s; v.ratio = rat; v.high = hi;
        v.e_clk = xc; v.e_rise = xr; v.e_fall = xf; v.e_run = xu;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        step("reset", 1'b0, '0, 1'b0, '0, '0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    endtask

    initial begin
        logic [CH*W-1:0] r_a;
        logic [CH*W-1:0] h_a;

        rst_n = 1'b0; en = '0; sync = 1'b0; div_ratio = '0; high_cnt = '0;
        @(posedge clk);
        #1;

        // ---------------- table: basic ratio 5 / high 2 on channel 0 ----------------
        r_a = pk(8'd5, 8'd0, 8'd0, 8'd0);
        h_a = pk(8'd2, 8'd0, 8'd0, 8'd0);
        add(1'b0, 4'b0000, 1'b0, r_a, h_a, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(1'b1, 4'b0001, 1'b0, r_a, h_a, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
        add(1'b1, 4'b0001, 1'b0, r_a, h_a, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        add(1'b1, 4'b0001, 1'b0, r_a, h_a, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
        add(1'b1, 4'b0001, 1'b0, r_a, h_a, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add(1'b1, 4'b0001, 1'b0, r_a, h_a, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add(1'b1, 4'b0001, 1'b0, r_a, h_a, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
        add(1'b1, 4'b0001, 1'b0, r_a, h_a, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        add(1'b1, 4'b0001, 1'b0, r_a, h_a, 4'b0000, 4'b0000, 4'b0001, 4'b0001);

        // ---------------- table: clamping on all four channels ----------------
        // ch0 ratio 0, ch1 ratio 1 -> 2/1; ch2 ratio 4 high 0 -> 4/1; ch3 ratio 4 high 9 -> 4/3
        r_a = pk(8'd0, 8'd1, 8'd4, 8'd4);
        h_a = pk(8'd7, 8'd0, 8'd0, 8'd9);
        add(1'b0, 4'b0000, 1'b0, r_a, h_a, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(1'b1, 4'b1111, 1'b0, r_a, h_a, 4'b1111, 4'b1111, 4'b0000, 4'b1111);
        add(1'b1, 4'b1111, 1'b0, r_a, h_a, 4'b1000, 4'b0000, 4'b0111, 4'b1111);
        add(1'b1, 4'b1111, 1'b0, r_a, h_a, 4'b1011, 4'b0011, 4'b0000, 4'b1111);
        add(1'b1, 4'b1111, 1'b0, r_a, h_a, 4'b0000, 4'b0000, 4'b1011, 4'b1111);
        add(1'b1, 4'b1111, 1'b0, r_a, h_a, 4'b1111, 4'b1111, 4'b0000, 4'b1111);
        add(1'b1, 4'b1111, 1'b0, r_a, h_a, 4'b1000, 4'b0000, 4'b0111, 4'b1111);

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i].rst_n, tbl[i].en, tbl[i].sync, tbl[i].ratio,
                 tbl[i].high, tbl[i].e_clk, tbl[i].e_rise, tbl[i].e_fall, tbl[i].e_run);
        end

        // ---------------- ratio change 4 -> 6 on channel 1 at cnt=1 ----------------
        do_reset();
        r_a = pk(8'd0, 8'd4, 8'd0, 8'd0);
        h_a = pk(8'd0, 8'd2, 8'd0, 8'd0);
        step("chg c0", 1'b1, 4'b0010, 1'b0, r_a, h_a, 4'b0010, 4'b0010, 4'b0000, 4'b0010);
        step("chg c1", 1'b1, 4'b0010, 1'b0, r_a, h_a, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
        r_a = pk(8'd0, 8'd6, 8'd0, 8'd0);
        step("chg c2", 1'b1, 4'b0010, 1'b0, r_a, h_a, 4'b0000, 4'b0000, 4'b0010, 4'b0010);
        step("chg c3", 1'b1, 4'b0010, 1'b0, r_a, h_a, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
        step("chg p2", 1'b1, 4'b0010, 1'b0, r_a, h_a, 4'b0010, 4'b0010, 4'b0000, 4'b0010);
        step("chg p2c1", 1'b1, 4'b0010, 1'b0, r_a, h_a, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
        step("chg p2c2", 1'b1, 4'b0010, 1'b0, r_a, h_a, 4'b0000, 4'b0000, 4'b0010, 4'b0010);
        for (int k = 3; k < 6; k++)
            step($sformatf("chg p2c%0d", k), 1'b1, 4'b0010, 1'b0, r_a, h_a,
                 4'b0000, 4'b0000, 4'b0000, 4'b0010);
        step("chg p3", 1'b1, 4'b0010, 1'b0, r_a, h_a, 4'b0010, 4'b0010, 4'b0000, 4'b0010);

        // ---------------- drop en[2] at cnt=0 of ratio 8 / high 4 ----------------
        do_reset();
        r_a = pk(8'd0, 8'd0, 8'd8, 8'd0);
        h_a = pk(8'd0, 8'd0, 8'd4, 8'd0);
        step("stop c0", 1'b1, 4'b0100, 1'b0, r_a, h_a, 4'b0100, 4'b0100, 4'b0000, 4'b0100);
        for (int k = 1; k < 8; k++)
            step($sformatf("stop c%0d", k), 1'b1, 4'b0000, 1'b0, r_a, h_a,
                 (k < 4) ? 4'b0100 : 4'b0000, 4'b0000,
                 (k == 4) ? 4'b0100 : 4'b0000, 4'b0100);
        step("stop idle", 1'b1, 4'b0000, 1'b0, r_a, h_a, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("stop idle2", 1'b1, 4'b0000, 1'b0, r_a, h_a, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // ---------------- drop en[2], re-enable at cnt=5: seamless ----------------
        do_reset();
        step("reen c0", 1'b1, 4'b0100, 1'b0, r_a, h_a, 4'b0100, 4'b0100, 4'b0000, 4'b0100);
        for (int k = 1; k < 8; k++)
            step($sformatf("reen c%0d", k), 1'b1, (k >= 6) ? 4'b0100 : 4'b0000, 1'b0, r_a, h_a,
                 (k < 4) ? 4'b0100 : 4'b0000, 4'b0000,
                 (k == 4) ? 4'b0100 : 4'b0000, 4'b0100);
        step("reen p2", 1'b1, 4'b0100, 1'b0, r_a, h_a, 4'b0100, 4'b0100, 4'b0000, 4'b0100);

        // ---------------- sync: ch0 ratio 3 / high 1, ch1 ratio 7 / high 3 ----------------
        do_reset();
        r_a = pk(8'd3, 8'd7, 8'd0, 8'd5);
        h_a = pk(8'd1, 8'd3, 8'd0, 8'd2);
        step("sync e0", 1'b1, 4'b0011, 1'b0, r_a, h_a, 4'b0011, 4'b0011, 4'b0000, 4'b0011);
        step("sync e1", 1'b1, 4'b0011, 1'b0, r_a, h_a, 4'b0010, 4'b0000, 4'b0001, 4'b0011);
        step("sync e2", 1'b1, 4'b0011, 1'b0, r_a, h_a, 4'b0010, 4'b0000, 4'b0000, 4'b0011);
        step("sync e3", 1'b1, 4'b0011, 1'b0, r_a, h_a, 4'b0001, 4'b0001, 4'b0010, 4'b0011);
        step("sync e4", 1'b1, 4'b0011, 1'b0, r_a, h_a, 4'b0000, 4'b0000, 4'b0001, 4'b0011);
        step("sync hit", 1'b1, 4'b0011, 1'b1, r_a, h_a, 4'b0011, 4'b0011, 4'b0000, 4'b0011);
        step("sync e6", 1'b1, 4'b0011, 1'b0, r_a, h_a, 4'b0010, 4'b0000, 4'b0001, 4'b0011);

        // ---------------- reset mid-period, en held high ----------------
        do_reset();
        r_a = pk(8'd5, 8'd0, 8'd0, 8'd0);
        h_a = pk(8'd2, 8'd0, 8'd0, 8'd0);
        step("rst e0", 1'b1, 4'b0001, 1'b0, r_a, h_a, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
        step("rst e1", 1'b1, 4'b0001, 1'b0, r_a, h_a, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        step("rst mid", 1'b0, 4'b0001, 1'b0, r_a, h_a, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("rst restart", 1'b1, 4'b0001, 1'b0, r_a, h_a, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
        step("rst r1", 1'b1, 4'b0001, 1'b0, r_a, h_a, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        step("rst r2", 1'b1, 4'b0001, 1'b0, r_a, h_a, 4'b0000, 4'b0000, 4'b0001, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
- Multi-channel programmable clock generator driven from one system clock.
- Each channel produces a registered divided clock with programmable period and high time, plus single-cycle rise/fall tick strobes.
- Ratio and duty changes are glitch-free. Stops are graceful. A global sync realigns all running channels.
- Next-generation replacement for the fixed divide-by-2 copy flop pair. Used wherever the design needs derived slow clocks or phase-aligned enables.

Parameters:
- CH, 4, number of independent output channels.
- W, 8, width of per-channel ratio and high-time fields.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- en  in  CH  per-channel enable.
- sync  in  1  global phase-realign strobe.
- div_ratio  in  CH*W  per-channel period in clk cycles; channel i uses bits [i*W +: W].
- high_cnt  in  CH*W  per-channel high time in clk cycles; same packing as div_ratio.
- clk_out  out  CH  divided clocks, registered.
- tick_rise  out  CH  1-cycle pulse in the first high cycle of each period.
- tick_fall  out  CH  1-cycle pulse in the first low cycle of each period.
- running  out  CH  channel is active (in a period).

Behaviour:
- Reset is synchronous: rst_n sampled low at a rising edge.
  - Reset values: clk_out=0, tick_rise=0, tick_fall=0, running=0, cnt=0.
  - Shadow ratio=2, shadow high=1.
  - Reset mid-period aborts immediately; no tail period.
- Operand clamping, applied when operands are loaded into the shadow registers:
  - R = div_ratio if div_ratio >= 2, else 2.
  - H = high_cnt clamped to [1, R-1].
  - Result: every period contains at least one high and one low cycle.
- Per-channel state: IDLE / RUN (running=1). Counter cnt runs 0..R-1. clk_out is 1 exactly while cnt < H.
- IDLE -> RUN: en=1 sampled at edge n.
  - At edge n: load shadows, cnt<=0, clk_out<=1, tick_rise<=1.
  - clk_out is high in the cycle following edge n.
- RUN, cnt < R-1: cnt<=cnt+1.
  - When cnt+1 == H: clk_out<=0 and tick_fall<=1.
- RUN, cnt == R-1 (period end):
  - If en=1: reload shadows from inputs, cnt<=0, clk_out<=1, tick_rise<=1.
  - If en=0: go to IDLE with clk_out=0 and cnt=0.
- Input changes mid-period have no effect until the next period end. Output is never truncated or stretched mid-period.
- en dropped mid-period: the current period completes.
  - If en returns before the period end, the channel continues seamlessly with no gap.
- sync=1 at an edge, for every channel with en=1 (RUN or IDLE):
  - Reload shadows, cnt<=0, clk_out<=1, tick_rise<=1.
  - Takes priority over the period-end and fall actions in that cycle.
  - A sync hitting the very cycle after a rise gives a 1-cycle-high period. This is accepted.
- Channels with en=0 ignore sync. A RUN channel with en=0 finishes its period normally.
- Tick strobes last exactly one cycle; they are coincident with the new clk_out level, not before it.
- Channels are fully independent except for the shared sync.

Decomposition:
- Shared include: default shadow values (ratio 2, high 1), minimum ratio constant 2, state encoding IDLE/RUN.
- Sub-module clk_div_chan holds one channel: counter, shadow registers, clamp logic, FSM.
- Top level generate-instantiates CH copies and slices the packed buses.

Test Plan:
- Reset, then en[0]=1 with ratio=5, high=2:
  - clk_out[0] repeats 1,1,0,0,0.
  - tick_rise every 5 cycles; tick_fall 2 cycles after each tick_rise.
  - running[0]=1.
- Ratio 0, 1, and high=0 and high=9 with ratio=4:
  - Ratio 0 and 1 behave as ratio 2, high 1 (clk_out toggles 1,0).
  - high 0 -> 1,0,0,0; high 9 -> 1,1,1,0.
- Change ratio 4->6 on channel 1 at cnt=1:
  - Current period stays 4 cycles.
  - Next period is 6 cycles; no glitch or short pulse.
- Drop en[2] at cnt=0 of a ratio-8/high-4 period:
  - Full 8-cycle period completes, then clk_out=0 and running=0.
  - Re-enable at cnt=5 instead: no gap between periods.
- Channels 0 and 1 at ratios 3 and 7, pulse sync:
  - Next cycle both show clk_out=1 with tick_rise=1 simultaneously.
  - A disabled channel 3 stays 0.
- Assert rst_n=0 mid-period for 1 cycle:
  - All outputs are 0 after that edge.
  - With en still high, the channel restarts on the next edge with tick_rise=1.
